// File: rtl/parity_frame_rx.sv
// parity_frame_rx
//   Checking end of the XOR parity link. Deserializes one frame of DATA_W
//   data bits (LSB first) followed by one parity bit, recomputes parity with
//   a running XOR and reports the word, a mismatch flag and a saturating
//   count of mismatched frames.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle frame-start strobe (also aborts a frame in flight)
//   bit_in     : serial data / parity bit
//   bit_valid  : bit_in is sampled on a rising edge while high
//   data_out   : data word of the last completed frame
//   data_valid : one-cycle pulse when a frame completes
//   parity_err : 1 when the last completed frame had a parity mismatch
//   err_cnt    : saturating count of mismatched frames
//   busy       : high while in DATA or PARITY
module parity_frame_rx #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          ODD       = 1'b0,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_t;

    state_t                 state_q,    state_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [DATA_W-1:0]      shift_q,    shift_d;
    logic                   par_q,      par_d;
    logic [DATA_W-1:0]      data_out_q, data_out_d;
    logic                   perr_q,     perr_d;
    logic                   pend_q,     pend_d;
    logic                   dv_q,       dv_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q,  err_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            data_out_q <= '0;
            perr_q     <= 1'b0;
            pend_q     <= 1'b0;
            dv_q       <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            data_out_q <= data_out_d;
            perr_q     <= perr_d;
            pend_q     <= pend_d;
            dv_q       <= dv_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        data_out_d = data_out_q;
        perr_d     = perr_q;
        pend_d     = 1'b0;
        dv_d       = 1'b0;
        err_cnt_d  = err_cnt_q;

        // The parity edge latches word and flag and arms pend; the completion
        // pulse and the error count follow one edge later, so the FSM is
        // already back in IDLE while data_valid is high.
        if (pend_q) begin
            dv_d = 1'b1;
            if (perr_q && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end

        // start wins in every state: a frame in flight is dropped and any
        // bit_valid in the same cycle is ignored.
        if (start) begin
            state_d = S_DATA;
            cnt_d   = '0;
            shift_d = '0;
            par_d   = ODD;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_DATA: begin
                    if (bit_valid) begin
                        shift_d = shift_q | (DATA_W'(bit_in) << cnt_q);
                        par_d   = par_q ^ bit_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_d = S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_valid) begin
                        state_d    = S_IDLE;
                        data_out_d = shift_q;
                        perr_d     = par_q ^ bit_in;
                        pend_d     = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: DATA_W=8, even parity, 8-bit counter
    logic       rst_n0, start0, bit_in0, bit_valid0;
    logic [7:0] data_out0;
    logic       dv0, perr0, busy0;
    logic [7:0] err_cnt0;

    // DUT 1: DATA_W=8, odd parity, 2-bit counter
    logic       rst_n1, start1, bit_in1, bit_valid1;
    logic [7:0] data_out1;
    logic       dv1, perr1, busy1;
    logic [1:0] err_cnt1;

    parity_frame_rx #(.DATA_W(8), .ODD(1'b0), .ERR_CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .start(start0), .bit_in(bit_in0),
        .bit_valid(bit_valid0), .data_out(data_out0), .data_valid(dv0),
        .parity_err(perr0), .err_cnt(err_cnt0), .busy(busy0)
    );

    parity_frame_rx #(.DATA_W(8), .ODD(1'b1), .ERR_CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start1), .bit_in(bit_in1),
        .bit_valid(bit_valid1), .data_out(data_out1), .data_valid(dv1),
        .parity_err(perr1), .err_cnt(err_cnt1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int checks = 0;
    int passes = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d, logic s, logic bv, logic bi);
        if (d == 0) begin start0 = s; bit_valid0 = bv; bit_in0 = bi; end
        else        begin start1 = s; bit_valid1 = bv; bit_in1 = bi; end
    endtask

    task automatic send_bit(int d, logic b, int gap);
        for (int g = 0; g < gap; g++) begin
            drive(d, 1'b0, 1'b0, 1'bx);
            tick();
        end
        drive(d, 1'b0, 1'b1, b);
        tick();
    endtask

    // Full frame: start (optionally with a bit_valid that must be ignored),
    // 8 data bits LSB first, then parity. Expected result is queued first.
    task automatic send_frame(int d, logic [7:0] data, logic p, int gap,
                              logic start_bv, logic exp_perr, logic [7:0] exp_cnt);
        exp_t e;
        e.data = data; e.perr = exp_perr; e.cnt = exp_cnt;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        drive(d, 1'b1, start_bv, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) send_bit(d, data[i], gap);
        send_bit(d, p, gap);
        drive(d, 1'b0, 1'b0, 1'bx);
        if (d == 0) begin
            check("busy0_after_parity", busy0, 0);
            check("dv0_latency", dv0, 0);
        end else begin
            check("busy1_after_parity", busy1, 0);
            check("dv1_latency", dv1, 0);
        end
    endtask

    task automatic mon_one(int d, logic dv, logic prev, logic [7:0] dout,
                           logic perr, logic [7:0] cnt);
        exp_t e;
        if (!dv) return;
        if (d == 0) check("dv0_pulse_width", prev, 0);
        else        check("dv1_pulse_width", prev, 0);
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            check(d == 0 ? "dv0_unexpected" : "dv1_unexpected", dv, 0);
            return;
        end
        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check(d == 0 ? "data_out0" : "data_out1", dout, e.data);
        check(d == 0 ? "parity_err0" : "parity_err1", perr, e.perr);
        check(d == 0 ? "err_cnt0" : "err_cnt1", cnt, e.cnt);
    endtask

    task automatic monitor();
        logic prev0, prev1;
        prev0 = 1'b0;
        prev1 = 1'b0;
        forever begin
            @(negedge clk);
            mon_one(0, dv0, prev0, data_out0, perr0, err_cnt0);
            mon_one(1, dv1, prev1, data_out1, perr1, {6'd0, err_cnt1});
            prev0 = dv0;
            prev1 = dv1;
        end
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        fork
            monitor();
        join_none
        tick();
        tick();
        check("rst_data_out0", data_out0, 0);
        check("rst_dv0", dv0, 0);
        check("rst_perr0", perr0, 0);
        check("rst_err_cnt0", err_cnt0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_err_cnt1", err_cnt1, 0);
        check("rst_busy1", busy1, 0);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        tick();

        // even parity DUT
        send_frame(0, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 8'd0);
        send_frame(0, 8'h07, 1'b0, 0, 1'b0, 1'b1, 8'd1);
        send_frame(0, 8'h07, 1'b1, 0, 1'b0, 1'b0, 8'd1);
        send_frame(0, 8'h3C, 1'b0, 3, 1'b1, 1'b0, 8'd1);

        // abort after 4 bits, then restart with a full frame
        drive(0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 0);
        check("busy0_mid_frame", busy0, 1);
        send_frame(0, 8'h81, 1'b0, 0, 1'b0, 1'b0, 8'd1);

        // async reset mid-frame, between edges
        tick();
        tick();
        drive(0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1, 0);
        drive(0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n0 = 1'b0;
        #1;
        check("arst_busy0", busy0, 0);
        check("arst_data_out0", data_out0, 0);
        check("arst_err_cnt0", err_cnt0, 0);
        check("arst_perr0", perr0, 0);
        tick();
        rst_n0 = 1'b1;
        tick();
        send_frame(0, 8'h5A, 1'b0, 0, 1'b0, 1'b0, 8'd0);

        // odd parity DUT, 2-bit saturating counter
        send_frame(1, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'd1);
        send_frame(1, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'd2);
        send_frame(1, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'd3);
        send_frame(1, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'd3);
        send_frame(1, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'd3);
        send_frame(1, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'd3);

        for (int w = 0; w < 50 && (exp_q0.size() != 0 || exp_q1.size() != 0); w++) tick();
        tick();
        check("pending_q0", exp_q0.size(), 0);
        check("pending_q1", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
